// File: rtl/fm_write_sched_if.sv
// CPU-side write port and the two FM chip write buses of fm_write_sched.
// The master modport is the CPU/chip side; the slave modport is the scheduler.
interface fm_write_sched_if;
    logic       cen_opn;
    logic       cen_opl;
    logic       wr_req;
    logic       wr_chip;
    logic       wr_a0;
    logic [7:0] wr_data;
    logic       wr_full;
    logic       ovf;
    logic       busy;
    logic       opn_cs_n;
    logic       opn_wr_n;
    logic       opn_addr;
    logic [7:0] opn_din;
    logic       opl_cs_n;
    logic       opl_wr_n;
    logic       opl_addr;
    logic [7:0] opl_din;

    modport master (
        output cen_opn, cen_opl, wr_req, wr_chip, wr_a0, wr_data,
        input  wr_full, ovf, busy,
        input  opn_cs_n, opn_wr_n, opn_addr, opn_din,
        input  opl_cs_n, opl_wr_n, opl_addr, opl_din
    );

    modport slave (
        input  cen_opn, cen_opl, wr_req, wr_chip, wr_a0, wr_data,
        output wr_full, ovf, busy,
        output opn_cs_n, opn_wr_n, opn_addr, opn_din,
        output opl_cs_n, opl_wr_n, opl_addr, opl_din
    );
endinterface

// File: rtl/fm_write_sched.sv
// In-order write FIFO feeding the OPN (chip 0) and OPL (chip 1) write strobes,
// with a per-chip recovery gap counted in that chip's own clock-enable ticks.
module fm_write_sched #(
    parameter int DEPTH    = 8,
    parameter int ADDR_GAP = 12,
    parameter int DATA_GAP = 84
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    fm_write_sched_if.slave  bus
);
    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    localparam int GAP_MAX = (ADDR_GAP > DATA_GAP) ? ADDR_GAP : DATA_GAP;
    localparam int GW      = $clog2(GAP_MAX + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STROBE = 1'b1;

    logic [9:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic [0:0]    r_state;
    logic [0:0]    w_state_next;
    logic          r_cur_chip;
    logic          r_cur_a0;
    logic          r_full;
    logic          r_ovf;
    logic          r_busy;

    logic [1:0]    w_cen;
    logic [9:0]    w_head;
    logic          w_head_chip;
    logic          w_head_a0;
    logic [7:0]    w_head_data;
    logic [1:0]    w_gap_zero;
    logic [1:0]    w_gap_next_zero;
    logic [1:0]    w_cs_n;
    logic [1:0]    w_addr;
    logic [15:0]   w_din;
    logic          w_pop;
    logic          w_push;
    logic          w_strobe_done;

    assign w_cen       = {bus.cen_opl, bus.cen_opn};
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_chip = w_head[9];
    assign w_head_a0   = w_head[8];
    assign w_head_data = w_head[7:0];

    // The head may only leave when its own chip has finished recovering;
    // a blocked head stalls everything behind it.
    assign w_pop         = (r_state == ST_IDLE) && (r_count != '0) && w_gap_zero[w_head_chip];
    assign w_push        = bus.wr_req && ((r_count != CW'(DEPTH)) || w_pop);
    assign w_strobe_done = (r_state == ST_STROBE) && w_cen[r_cur_chip];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        if (w_pop)
            w_state_next = ST_STROBE;
        else if (w_strobe_done)
            w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk_sys) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {bus.wr_chip, bus.wr_a0, bus.wr_data};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= ST_IDLE;
            r_cur_chip <= 1'b0;
            r_cur_a0   <= 1'b0;
            r_full     <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_cur_chip <= w_head_chip;
                r_cur_a0   <= w_head_a0;
            end
            r_count <= w_count_next;
            r_state <= w_state_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_ovf   <= r_ovf | (bus.wr_req & ~w_push);
            r_busy  <= (w_count_next != '0) || (w_state_next == ST_STROBE) || !(&w_gap_next_zero);
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chip
            logic [GW-1:0] r_gap;
            logic [GW-1:0] w_gap_next;
            logic          r_cs_n;
            logic          r_addr;
            logic [7:0]    r_din;
            logic          w_mine_done;
            logic          w_mine_issue;

            assign w_mine_done  = w_strobe_done && (r_cur_chip == 1'(gi));
            assign w_mine_issue = w_pop && (w_head_chip == 1'(gi));

            always_comb begin
                w_gap_next = r_gap;
                if (w_mine_done)
                    w_gap_next = r_cur_a0 ? GW'(DATA_GAP) : GW'(ADDR_GAP);
                else if (w_cen[gi] && (r_gap != '0))
                    w_gap_next = r_gap - 1'b1;
            end

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    r_gap  <= '0;
                    r_cs_n <= 1'b1;
                    r_addr <= 1'b0;
                    r_din  <= 8'h00;
                end else begin
                    r_gap <= w_gap_next;
                    if (w_mine_issue) begin
                        r_cs_n <= 1'b0;
                        r_addr <= w_head_a0;
                        r_din  <= w_head_data;
                    end else if (w_mine_done) begin
                        r_cs_n <= 1'b1;
                    end
                end
            end

            assign w_gap_zero[gi]      = (r_gap == '0);
            assign w_gap_next_zero[gi] = (w_gap_next == '0);
            assign w_cs_n[gi]          = r_cs_n;
            assign w_addr[gi]          = r_addr;
            assign w_din[gi*8 +: 8]    = r_din;
        end
    endgenerate

    assign bus.wr_full  = r_full;
    assign bus.ovf      = r_ovf;
    assign bus.busy     = r_busy;
    assign bus.opn_cs_n = w_cs_n[0];
    assign bus.opn_wr_n = w_cs_n[0];
    assign bus.opn_addr = w_addr[0];
    assign bus.opn_din  = w_din[7:0];
    assign bus.opl_cs_n = w_cs_n[1];
    assign bus.opl_wr_n = w_cs_n[1];
    assign bus.opl_addr = w_addr[1];
    assign bus.opl_din  = w_din[15:8];
endmodule

// File: tb/tb_fm_write_sched.sv
// Directed bench for fm_write_sched with DEPTH=4, ADDR_GAP=2, DATA_GAP=4.
// Each task drives one scenario and checks hand-computed cycle-exact values.
module tb_fm_write_sched;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    fm_write_sched_if bus ();

    fm_write_sched #(
        .DEPTH   (4),
        .ADDR_GAP(2),
        .DATA_GAP(4)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int opn_per = 0;
    int opl_per = 0;
    int opn_cnt = 0;
    int opl_cnt = 0;
    bit wrn_bad  = 1'b0;
    bit dual_bad = 1'b0;
    logic [9:0] issued_q[$];

    // One clock edge; outputs are observed 1 ns later, next-edge inputs set here.
    task automatic tick();
        logic p_opn;
        logic p_opl;
        p_opn = bus.opn_cs_n;
        p_opl = bus.opl_cs_n;
        @(posedge clk_sys);
        #1;
        cyc++;
        if (p_opn === 1'b1 && bus.opn_cs_n === 1'b0) begin
            issued_q.push_back({1'b0, bus.opn_addr, bus.opn_din});
            $display("[TB] cyc %0d issue OPN a0=%0d din=%02h", cyc, bus.opn_addr, bus.opn_din);
        end
        if (p_opl === 1'b1 && bus.opl_cs_n === 1'b0) begin
            issued_q.push_back({1'b1, bus.opl_addr, bus.opl_din});
            $display("[TB] cyc %0d issue OPL a0=%0d din=%02h", cyc, bus.opl_addr, bus.opl_din);
        end
        if (bus.opn_wr_n !== bus.opn_cs_n || bus.opl_wr_n !== bus.opl_cs_n) wrn_bad = 1'b1;
        if (bus.opn_cs_n === 1'b0 && bus.opl_cs_n === 1'b0) dual_bad = 1'b1;
        bus.wr_req = 1'b0;
        if (opn_per == 0) bus.cen_opn = 1'b0;
        else begin opn_cnt = (opn_cnt + 1) % opn_per; bus.cen_opn = (opn_cnt == 0); end
        if (opl_per == 0) bus.cen_opl = 1'b0;
        else begin opl_cnt = (opl_cnt + 1) % opl_per; bus.cen_opl = (opl_cnt == 0); end
    endtask

    // Period 0 holds the enable low, 1 keeps it high, N pulses every N edges.
    task automatic set_cen(input int pn, input int pl);
        opn_per = pn;
        opl_per = pl;
        opn_cnt = 0;
        opl_cnt = 0;
        bus.cen_opn = (pn == 1);
        bus.cen_opl = (pl == 1);
    endtask

    task automatic push(input logic chip, input logic a0, input logic [7:0] data);
        bus.wr_req  = 1'b1;
        bus.wr_chip = chip;
        bus.wr_a0   = a0;
        bus.wr_data = data;
        $display("[TB] cyc %0d push chip=%0d a0=%0d data=%02h", cyc + 1, chip, a0, data);
        tick();
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            $display("[TB] FAIL idle_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        set_cen(1, 1);
        for (int i = 0; i < 6; i++) begin
            bus.wr_req  = i[0];
            bus.wr_chip = i[1];
            bus.wr_a0   = 1'b1;
            bus.wr_data = 8'hA5;
            tick();
        end
        n_tests++; if ({bus.opn_cs_n, bus.opn_wr_n, bus.opl_cs_n, bus.opl_wr_n} !== 4'b1111) begin $display("[TB] FAIL reset_strobes: got %b required 1111", {bus.opn_cs_n, bus.opn_wr_n, bus.opl_cs_n, bus.opl_wr_n}); n_fail++; end
        n_tests++; if ({bus.opn_addr, bus.opn_din, bus.opl_addr, bus.opl_din} !== 18'h0) begin $display("[TB] FAIL reset_addr_din: got %h required 0", {bus.opn_addr, bus.opn_din, bus.opl_addr, bus.opl_din}); n_fail++; end
        n_tests++; if ({bus.wr_full, bus.ovf, bus.busy} !== 3'b000) begin $display("[TB] FAIL reset_flags: full/ovf/busy got %b required 000", {bus.wr_full, bus.ovf, bus.busy}); n_fail++; end
        reset_n = 1'b1;
        repeat (3) tick();
        n_tests++; if (bus.busy !== 1'b0 || bus.opn_cs_n !== 1'b1 || bus.opl_cs_n !== 1'b1) begin $display("[TB] FAIL reset_release: busy=%b opn_cs_n=%b opl_cs_n=%b required 0 1 1", bus.busy, bus.opn_cs_n, bus.opl_cs_n); n_fail++; end
    endtask

    task automatic test_single_write();
        set_cen(4, 0);
        push(1'b0, 1'b0, 8'h28);
        n_tests++; if (bus.opn_cs_n !== 1'b1 || bus.busy !== 1'b1) begin $display("[TB] FAIL single_t0: opn_cs_n=%b busy=%b required 1 1", bus.opn_cs_n, bus.busy); n_fail++; end
        tick();
        n_tests++; if (bus.opn_cs_n !== 1'b0 || bus.opn_wr_n !== 1'b0) begin $display("[TB] FAIL single_t1_strobe: cs_n=%b wr_n=%b required 0 0", bus.opn_cs_n, bus.opn_wr_n); n_fail++; end
        n_tests++; if (bus.opn_addr !== 1'b0 || bus.opn_din !== 8'h28) begin $display("[TB] FAIL single_t1_bus: addr=%b din=%02h required 0 28", bus.opn_addr, bus.opn_din); n_fail++; end
        repeat (2) tick();
        n_tests++; if (bus.opn_cs_n !== 1'b0) begin $display("[TB] FAIL single_t3_hold: opn_cs_n=%b required 0", bus.opn_cs_n); n_fail++; end
        tick();
        n_tests++; if (bus.opn_cs_n !== 1'b1 || bus.opn_wr_n !== 1'b1) begin $display("[TB] FAIL single_t4_release: cs_n=%b wr_n=%b required 1 1", bus.opn_cs_n, bus.opn_wr_n); n_fail++; end
        repeat (7) tick();
        n_tests++; if (bus.busy !== 1'b1) begin $display("[TB] FAIL single_t11_busy: busy=%b required 1", bus.busy); n_fail++; end
        tick();
        n_tests++; if (bus.busy !== 1'b0) begin $display("[TB] FAIL single_t12_idle: busy=%b required 0", bus.busy); n_fail++; end
    endtask

    task automatic test_addr_data_opl();
        set_cen(0, 1);
        push(1'b1, 1'b0, 8'hBD);
        push(1'b1, 1'b1, 8'h20);
        n_tests++; if (bus.opl_cs_n !== 1'b0 || bus.opl_addr !== 1'b0 || bus.opl_din !== 8'hBD) begin $display("[TB] FAIL opl_first: cs_n=%b addr=%b din=%02h required 0 0 bd", bus.opl_cs_n, bus.opl_addr, bus.opl_din); n_fail++; end
        tick();
        n_tests++; if (bus.opl_cs_n !== 1'b1) begin $display("[TB] FAIL opl_first_end: cs_n=%b required 1", bus.opl_cs_n); n_fail++; end
        repeat (2) tick();
        n_tests++; if (bus.opl_cs_n !== 1'b1) begin $display("[TB] FAIL opl_gap_hold: cs_n=%b required 1", bus.opl_cs_n); n_fail++; end
        tick();
        n_tests++; if (bus.opl_cs_n !== 1'b0 || bus.opl_addr !== 1'b1 || bus.opl_din !== 8'h20) begin $display("[TB] FAIL opl_second: cs_n=%b addr=%b din=%02h required 0 1 20", bus.opl_cs_n, bus.opl_addr, bus.opl_din); n_fail++; end
        tick();
        n_tests++; if (bus.opl_cs_n !== 1'b1) begin $display("[TB] FAIL opl_second_end: cs_n=%b required 1", bus.opl_cs_n); n_fail++; end
        repeat (3) tick();
        n_tests++; if (bus.busy !== 1'b1) begin $display("[TB] FAIL opl_data_gap_busy: busy=%b required 1", bus.busy); n_fail++; end
        tick();
        n_tests++; if (bus.busy !== 1'b0) begin $display("[TB] FAIL opl_data_gap_idle: busy=%b required 0", bus.busy); n_fail++; end
    endtask

    task automatic test_cross_chip();
        set_cen(0, 1);
        push(1'b1, 1'b1, 8'h55);
        push(1'b0, 1'b1, 8'h9C);
        n_tests++; if (bus.opl_cs_n !== 1'b0 || bus.opn_cs_n !== 1'b1) begin $display("[TB] FAIL cross_t1: opl_cs_n=%b opn_cs_n=%b required 0 1", bus.opl_cs_n, bus.opn_cs_n); n_fail++; end
        tick();
        n_tests++; if (bus.opl_cs_n !== 1'b1 || bus.opn_cs_n !== 1'b1) begin $display("[TB] FAIL cross_t2: opl_cs_n=%b opn_cs_n=%b required 1 1", bus.opl_cs_n, bus.opn_cs_n); n_fail++; end
        tick();
        n_tests++; if (bus.opn_cs_n !== 1'b0 || bus.opn_addr !== 1'b1 || bus.opn_din !== 8'h9C) begin $display("[TB] FAIL cross_t3_opn: cs_n=%b addr=%b din=%02h required 0 1 9c", bus.opn_cs_n, bus.opn_addr, bus.opn_din); n_fail++; end
        repeat (4) tick();
        n_tests++; if (bus.opn_cs_n !== 1'b0 || bus.opl_din !== 8'h55) begin $display("[TB] FAIL cross_hold: opn_cs_n=%b opl_din=%02h required 0 55", bus.opn_cs_n, bus.opl_din); n_fail++; end
        set_cen(1, 1);
        tick();
        n_tests++; if (bus.opn_cs_n !== 1'b1) begin $display("[TB] FAIL cross_opn_end: cs_n=%b required 1", bus.opn_cs_n); n_fail++; end
        wait_idle(50);
    endtask

    task automatic test_overflow();
        logic [9:0] exp_q[5];
        exp_q[0] = {1'b0, 1'b0, 8'h01};
        exp_q[1] = {1'b1, 1'b0, 8'h02};
        exp_q[2] = {1'b0, 1'b1, 8'h03};
        exp_q[3] = {1'b1, 1'b1, 8'h04};
        exp_q[4] = {1'b0, 1'b0, 8'h05};
        set_cen(0, 0);
        issued_q.delete();
        push(1'b0, 1'b0, 8'h01);
        push(1'b1, 1'b0, 8'h02);
        n_tests++; if (bus.opn_cs_n !== 1'b0 || bus.wr_full !== 1'b0) begin $display("[TB] FAIL ovf_first_strobe: opn_cs_n=%b full=%b required 0 0", bus.opn_cs_n, bus.wr_full); n_fail++; end
        push(1'b0, 1'b1, 8'h03);
        push(1'b1, 1'b1, 8'h04);
        n_tests++; if (bus.wr_full !== 1'b0) begin $display("[TB] FAIL ovf_full_early: full=%b required 0", bus.wr_full); n_fail++; end
        push(1'b0, 1'b0, 8'h05);
        n_tests++; if (bus.wr_full !== 1'b1 || bus.ovf !== 1'b0) begin $display("[TB] FAIL ovf_full_at5: full=%b ovf=%b required 1 0", bus.wr_full, bus.ovf); n_fail++; end
        push(1'b1, 1'b1, 8'h06);
        n_tests++; if (bus.ovf !== 1'b1 || bus.wr_full !== 1'b1) begin $display("[TB] FAIL ovf_drop6: ovf=%b full=%b required 1 1", bus.ovf, bus.wr_full); n_fail++; end
        set_cen(1, 1);
        wait_idle(300);
        n_tests++; if (issued_q.size() != 5) begin $display("[TB] FAIL ovf_drain_count: issued %0d required 5", issued_q.size()); n_fail++; end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (i >= issued_q.size()) begin $display("[TB] FAIL ovf_drain_%0d: missing entry, required %03h", i, exp_q[i]); n_fail++; end
            else if (issued_q[i] !== exp_q[i]) begin $display("[TB] FAIL ovf_drain_%0d: got %03h required %03h", i, issued_q[i], exp_q[i]); n_fail++; end
        end
        n_tests++; if (bus.ovf !== 1'b1 || bus.wr_full !== 1'b0) begin $display("[TB] FAIL ovf_sticky: ovf=%b full=%b required 1 0", bus.ovf, bus.wr_full); n_fail++; end
    endtask

    task automatic test_reset_mid_strobe();
        set_cen(0, 0);
        push(1'b1, 1'b0, 8'h77);
        push(1'b0, 1'b0, 8'h11);
        n_tests++; if (bus.opl_cs_n !== 1'b0) begin $display("[TB] FAIL midrst_pre: opl_cs_n=%b required 0", bus.opl_cs_n); n_fail++; end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (bus.opl_cs_n !== 1'b1 || bus.opl_wr_n !== 1'b1) begin $display("[TB] FAIL midrst_async: opl_cs_n=%b wr_n=%b required 1 1", bus.opl_cs_n, bus.opl_wr_n); n_fail++; end
        n_tests++; if ({bus.ovf, bus.busy, bus.wr_full} !== 3'b000) begin $display("[TB] FAIL midrst_flags: ovf/busy/full got %b required 000", {bus.ovf, bus.busy, bus.wr_full}); n_fail++; end
        repeat (2) tick();
        reset_n = 1'b1;
        issued_q.delete();
        set_cen(1, 1);
        repeat (30) tick();
        n_tests++; if (bus.busy !== 1'b0 || issued_q.size() != 0) begin $display("[TB] FAIL midrst_after: busy=%b strobes=%0d required 0 0", bus.busy, issued_q.size()); n_fail++; end
        n_tests++; if (bus.opl_din !== 8'h00 || bus.opn_din !== 8'h00) begin $display("[TB] FAIL midrst_din: opl_din=%02h opn_din=%02h required 00 00", bus.opl_din, bus.opn_din); n_fail++; end
    endtask

    task automatic test_invariants();
        n_tests++; if (wrn_bad !== 1'b0) begin $display("[TB] FAIL wr_n_equals_cs_n: violation flag=%b required 0", wrn_bad); n_fail++; end
        n_tests++; if (dual_bad !== 1'b0) begin $display("[TB] FAIL single_strobe: overlap flag=%b required 0", dual_bad); n_fail++; end
    endtask

    initial begin
        bus.cen_opn = 1'b0;
        bus.cen_opl = 1'b0;
        bus.wr_req  = 1'b0;
        bus.wr_chip = 1'b0;
        bus.wr_a0   = 1'b0;
        bus.wr_data = 8'h00;
        test_reset();
        test_single_write();
        test_addr_data_opl();
        test_cross_chip();
        test_overflow();
        test_reset_mid_strobe();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fm_write_sched.md
# fm_write_sched

Sound-side write scheduler for the two FM chips (YM2203 "OPN" and YM3526 "OPL"). It sits between the sound-CPU chip-select decode and the chip write ports. Every CPU write is captured into a small in-order FIFO, so the CPU never stalls on chip timing. Each write is issued to its target chip as a chip-select/write strobe held until that chip's clock enable samples it. After every write, a per-chip recovery gap is enforced, counted in that chip's own `cen` ticks.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `ADDR_GAP`, 12: target-chip `cen` ticks of recovery after an address write (`a0`=0).
- `DATA_GAP`, 84: target-chip `cen` ticks of recovery after a data write (`a0`=1).

- `clk_sys` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cen_opn` in 1: OPN clock enable, one `clk_sys` cycle wide.
- `cen_opl` in 1: OPL clock enable, one `clk_sys` cycle wide.
- `wr_req` in 1: one-cycle CPU write strobe.
- `wr_chip` in 1: target chip; 0 = OPN, 1 = OPL.
- `wr_a0` in 1: chip address bit.
- `wr_data` in 8: write data.
- `wr_full` out 1: FIFO holds `DEPTH` entries.
- `ovf` out 1: sticky flag; set when a write is dropped.
- `busy` out 1: FIFO non-empty, or a strobe is in progress, or either gap counter is non-zero.
- `opn_cs_n`, `opn_wr_n` out 1 each: OPN write strobe.
- `opn_addr` out 1, `opn_din` out 8: OPN address bit and data.
- `opl_cs_n`, `opl_wr_n` out 1 each: OPL write strobe.
- `opl_addr` out 1, `opl_din` out 8: OPL address bit and data.

## Operation
- FIFO entry format: {chip, a0, data}, 10 bits. Read and write pointers wrap modulo `DEPTH`. Count is `$clog2(DEPTH)+1` bits wide.
- Push:
  - `wr_req`=1 and count<`DEPTH`: entry is stored.
  - FIFO full and a pop happens in the same cycle: push is accepted and count is unchanged.
  - FIFO full and no pop in that cycle: entry is dropped and `ovf` is set. `ovf` clears only on reset.
- Gap counters: one per chip, width `$clog2(max(ADDR_GAP,DATA_GAP)+1)`.
  - Decremented on each `cen` of that chip while non-zero; saturates at 0.
  - A chip is *eligible* when its counter is 0.
- Issue FSM states are IDLE and STROBE.
  - IDLE → STROBE when the FIFO is non-empty and the head's target chip is eligible.
    - The entry is popped on this edge.
    - The target's `addr`/`din` registers load from the entry.
    - The target's `cs_n` and `wr_n` go to 0.
  - STROBE → IDLE on the edge where the target chip's `cen`=1.
    - `cs_n` and `wr_n` return to 1.
    - The target gap counter loads `ADDR_GAP` if a0=0, or `DATA_GAP` if a0=1.
  - Otherwise STROBE holds.
- Strict head-of-line order; no reordering.
  - A head entry for chip X issues while chip Y is still counting its gap.
  - A head entry blocked on its own gap blocks the whole FIFO.
- Only one strobe at a time across both chips.
- `wr_n` is always equal to `cs_n`. The block is write-only; chip status reads bypass it.
- `addr`/`din` hold their last issued value until that chip's next issue.

## Timing
- Reset values:
  - FIFO empty; FSM in IDLE; both gap counters 0.
  - All `cs_n`/`wr_n` = 1; all `addr` = 0, all `din` = 0x00.
  - `wr_full`, `ovf`, `busy` = 0.
- Reset mid-strobe: `cs_n` goes to 1 asynchronously. Queued entries are lost.
- Latency from a push into an empty FIFO with an eligible target:
  - Push sampled at edge t.
  - STROBE entered and `cs_n`=0 at edge t+1.
  - `cs_n`=1 at the first edge ≥ t+2 where the target `cen`=1. That edge is the chip's sampling edge.
- Spacing: consecutive sampling `cen` ticks to the same chip are ≥ GAP+2 ticks apart. GAP is the gap of the earlier write.
- A strobe to the other chip can start on the edge right after the previous strobe ends.
- `wr_full`, `busy`, `ovf` are registered. They reflect state after the current edge.
- `cen_opn` and `cen_opl` may coincide. Each affects only its own chip's strobe and counter.

## Test plan
- **Reset:** assert `reset_n`=0 with `wr_req` toggling → all outputs at their reset values; `busy`=0.
- **Single write:** `ADDR_GAP`=2; `cen_opn` every 4 cycles; push (0,0,0x28) → `opn_cs_n`=0 from t+1 until the first `cen_opn` edge; `opn_addr`=0, `opn_din`=0x28; `busy` falls 2 `cen_opn` ticks after the sampling edge.
- **Address then data to OPL:** `ADDR_GAP`=2, `DATA_GAP`=4; push (1,0,0xBD), (1,1,0x20) back-to-back → second sampling tick is exactly 4 `cen_opl` ticks after the first (`cen_opl` continuous); `busy` clears 4 ticks later.
- **Cross-chip overlap:** push OPL data, then an OPN write → OPN strobe starts on the edge after the OPL strobe ends, while the OPL counter is still non-zero.
- **Overflow:** `DEPTH`=4; both `cen` held at 0 through the pushes; push 6 distinct entries → `wr_full`=1 after 5 pushes (1 in strobe + 4 queued); 6th dropped; `ovf`=1; after releasing `cen`, the 5 entries drain in push order.
- **Reset mid-strobe:** drop `reset_n` while `opl_cs_n`=0 → `opl_cs_n`=1 immediately; after release, `busy`=0 and no further strobes.
